// File: rtl/alu_issue_wb.sv
// alu_issue_wb: operand issue and writeback stage around the 8-bit ALU.
// Three-cycle IDLE/ISSUE/WB sequence with a side-band register load port.
module alu_issue_wb #(
  parameter int NREGS  = 4,
  parameter int DATA_W = 8,
  parameter int OP_W   = 3,
  localparam int RW    = $clog2(NREGS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [OP_W-1:0]   cmd_op,
  input  logic [RW-1:0]     cmd_rd,
  input  logic [RW-1:0]     cmd_rs,
  input  logic [RW-1:0]     cmd_rt,
  input  logic              cmd_imm_en,
  input  logic [DATA_W-1:0] cmd_imm,
  input  logic              ld_en,
  input  logic [RW-1:0]     ld_rd,
  input  logic [DATA_W-1:0] ld_data,
  output logic              alu_en,
  output logic [OP_W-1:0]   alu_op,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  input  logic [DATA_W-1:0] alu_out,
  input  logic              alu_zero,
  input  logic              alu_carry,
  input  logic [RW-1:0]     rd_addr,
  output logic [DATA_W-1:0] rd_data,
  output logic              flag_z,
  output logic              flag_c,
  output logic              done
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WB    = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [OP_W-1:0]   op_q, op_d;
  logic [RW-1:0]     rd_q, rd_d;
  logic [DATA_W-1:0] a_q, a_d;
  logic [DATA_W-1:0] b_q, b_d;
  logic [DATA_W-1:0] regs_q [NREGS];
  logic [DATA_W-1:0] regs_d [NREGS];
  logic              flag_z_q, flag_z_d;
  logic              flag_c_q, flag_c_d;
  logic              alu_en_q, alu_en_d;
  logic              done_q, done_d;
  logic              ready_q, ready_d;

  // Next-state, operand latch, register file and flag update.
  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    rd_d     = rd_q;
    a_d      = a_q;
    b_d      = b_q;
    regs_d   = regs_q;
    flag_z_d = flag_z_q;
    flag_c_d = flag_c_q;

    unique case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          op_d    = cmd_op;
          rd_d    = cmd_rd;
          a_d     = regs_q[cmd_rs];
          b_d     = cmd_imm_en ? cmd_imm
                               : regs_q[cmd_rt];
          state_d = ISSUE;
        end
      end
      ISSUE: state_d = WB;
      WB:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (ld_en) regs_d[ld_rd] = ld_data;

    // Writeback is applied after the load so it wins a same-rd collision.
    if (state_q == WB) begin
      regs_d[rd_q] = alu_out;
      flag_z_d     = alu_zero;
      flag_c_d     = alu_carry;
    end

    alu_en_d = (state_d == ISSUE);
    done_d   = (state_d == WB);
    ready_d  = (state_d == IDLE);
  end

  // State, registered outputs and register file; reset aborts any command.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      op_q     <= '0;
      rd_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
      flag_z_q <= 1'b0;
      flag_c_q <= 1'b0;
      alu_en_q <= 1'b0;
      done_q   <= 1'b0;
      ready_q  <= 1'b1;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      rd_q     <= rd_d;
      a_q      <= a_d;
      b_q      <= b_d;
      regs_q   <= regs_d;
      flag_z_q <= flag_z_d;
      flag_c_q <= flag_c_d;
      alu_en_q <= alu_en_d;
      done_q   <= done_d;
      ready_q  <= ready_d;
    end
  end

  assign cmd_ready = ready_q;
  assign alu_en    = alu_en_q;
  assign alu_op    = op_q;
  assign alu_a     = a_q;
  assign alu_b     = b_q;
  assign flag_z    = flag_z_q;
  assign flag_c    = flag_c_q;
  assign done      = done_q;
  assign rd_data   = regs_q[rd_addr];

endmodule

// File: tb/tb_alu_issue_wb.sv
// tb_alu_issue_wb: vector table, corner sequences and random run
// against a transaction-level register/flag model.
module tb_alu_issue_wb;

  logic       clk = 1'b0;
  logic       rst;
  logic       cmd_valid, cmd_ready;
  logic [2:0] cmd_op;
  logic [1:0] cmd_rd, cmd_rs, cmd_rt;
  logic       cmd_imm_en;
  logic [7:0] cmd_imm;
  logic       ld_en;
  logic [1:0] ld_rd;
  logic [7:0] ld_data;
  logic       alu_en;
  logic [2:0] alu_op;
  logic [7:0] alu_a, alu_b;
  logic [7:0] alu_out   = 8'h00;
  logic       alu_zero  = 1'b0;
  logic       alu_carry = 1'b0;
  logic [1:0] rd_addr;
  logic [7:0] rd_data;
  logic       flag_z, flag_c, done;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  alu_issue_wb dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_rd(cmd_rd),
    .cmd_rs(cmd_rs), .cmd_rt(cmd_rt),
    .cmd_imm_en(cmd_imm_en), .cmd_imm(cmd_imm),
    .ld_en(ld_en), .ld_rd(ld_rd), .ld_data(ld_data),
    .alu_en(alu_en), .alu_op(alu_op),
    .alu_a(alu_a), .alu_b(alu_b),
    .alu_out(alu_out), .alu_zero(alu_zero),
    .alu_carry(alu_carry),
    .rd_addr(rd_addr), .rd_data(rd_data),
    .flag_z(flag_z), .flag_c(flag_c), .done(done)
  );

  // {carry, result}; SUB/DEC carry is the borrow.
  function automatic logic [8:0] alu_ref(
    input logic [2:0] op,
    input logic [7:0] a,
    input logic [7:0] b);
    case (op)
      3'd0: return {1'b0, a} + {1'b0, b};
      3'd1: return {a < b, 8'(a - b)};
      3'd2: return {1'b0, ~a};
      3'd3: return {1'b0, a & b};
      3'd4: return {1'b0, a | b};
      3'd5: return {1'b0, a ^ b};
      3'd6: return {a == 8'hFF, 8'(a + 8'd1)};
      default: return {a == 8'h00, 8'(a - 8'd1)};
    endcase
  endfunction

  // Registered ALU stand-in: result valid the cycle after alu_en.
  logic [8:0] stub_r;
  always_comb stub_r = alu_ref(alu_op, alu_a, alu_b);
  always @(posedge clk) begin
    if (alu_en) begin
      alu_out   <= stub_r[7:0];
      alu_carry <= stub_r[8];
      alu_zero  <= (stub_r[7:0] == 8'h00);
    end
  end

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h",
               name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_ld(input logic [1:0] r,
                       input logic [7:0] d);
    ld_en = 1'b1; ld_rd = r; ld_data = d;
    tick();
    ld_en = 1'b0;
  endtask

  typedef struct {
    logic [2:0] op;
    logic [1:0] rd, rs, rt;
    logic       imm_en;
    logic [7:0] imm;
    logic       pre_en;
    logic [1:0] pre_rd;
    logic [7:0] pre_d;
    logic       acc_en;
    logic [1:0] acc_rd;
    logic [7:0] acc_d;
    logic       wb_en;
    logic [1:0] wb_rd;
    logic [7:0] wb_d;
    logic [7:0] ea, eb, er;
    logic       ez, ec;
  } vec_t;

  vec_t tbl [13];

  task automatic run_vec(input vec_t v, input int k);
    string p;
    p = $sformatf("v%0d", k);
    if (v.pre_en) do_ld(v.pre_rd, v.pre_d);
    chk({p, "_ready_idle"}, 32'(cmd_ready), 32'd1);
    cmd_valid = 1'b1; cmd_op = v.op;
    cmd_rd = v.rd; cmd_rs = v.rs; cmd_rt = v.rt;
    cmd_imm_en = v.imm_en; cmd_imm = v.imm;
    ld_en = v.acc_en; ld_rd = v.acc_rd; ld_data = v.acc_d;
    tick();
    cmd_valid = 1'b0; ld_en = 1'b0;
    chk({p, "_issue_en"}, 32'(alu_en), 32'd1);
    chk({p, "_issue_rdy"}, 32'(cmd_ready), 32'd0);
    chk({p, "_issue_done"}, 32'(done), 32'd0);
    chk({p, "_alu_op"}, 32'(alu_op), 32'(v.op));
    chk({p, "_alu_a"}, 32'(alu_a), 32'(v.ea));
    chk({p, "_alu_b"}, 32'(alu_b), 32'(v.eb));
    ld_en = v.wb_en; ld_rd = v.wb_rd; ld_data = v.wb_d;
    tick();
    ld_en = 1'b0;
    chk({p, "_wb_en"}, 32'(alu_en), 32'd0);
    chk({p, "_wb_done"}, 32'(done), 32'd1);
    chk({p, "_wb_rdy"}, 32'(cmd_ready), 32'd0);
    tick();
    chk({p, "_post_done"}, 32'(done), 32'd0);
    chk({p, "_post_rdy"}, 32'(cmd_ready), 32'd1);
    chk({p, "_flag_z"}, 32'(flag_z), 32'(v.ez));
    chk({p, "_flag_c"}, 32'(flag_c), 32'(v.ec));
    rd_addr = v.rd; #1;
    chk({p, "_rd_val"}, 32'(rd_data), 32'(v.er));
    if (v.wb_en && v.wb_rd != v.rd) begin
      rd_addr = v.wb_rd; #1;
      chk({p, "_wb_ld"}, 32'(rd_data), 32'(v.wb_d));
    end
    if (v.acc_en && v.acc_rd != v.rd) begin
      rd_addr = v.acc_rd; #1;
      chk({p, "_acc_ld"}, 32'(rd_data), 32'(v.acc_d));
    end
  endtask

  // random-phase model state
  logic [7:0] mregs [4];
  logic       mz, mc;
  int         phase;
  logic [2:0] pop;
  logic [1:0] prd;
  logic [7:0] pa, pb;
  logic [8:0] pr;
  logic [7:0] na, nb;
  logic       acc;
  int         dut_acc;
  int         dsum;

  initial begin
    rst = 1'b1; cmd_valid = 1'b0; cmd_op = '0;
    cmd_rd = '0; cmd_rs = '0; cmd_rt = '0;
    cmd_imm_en = 1'b0; cmd_imm = '0;
    ld_en = 1'b0; ld_rd = '0; ld_data = '0; rd_addr = '0;

    //        op    rd    rs    rt    ie    imm
    //        pre              acc              wb
    //        ea     eb     er     ez    ec
    tbl[0]  = '{3'd0, 2'd0, 2'd1, 2'd2, 1'b0, 8'h00,
      1'b1, 2'd1, 8'h05, 1'b0, 2'd0, 8'h00, 1'b0, 2'd0, 8'h00,
      8'h05, 8'h03, 8'h08, 1'b0, 1'b0};
    tbl[1]  = '{3'd6, 2'd1, 2'd1, 2'd0, 1'b0, 8'h00,
      1'b1, 2'd1, 8'hFF, 1'b0, 2'd0, 8'h00, 1'b0, 2'd0, 8'h00,
      8'hFF, 8'h08, 8'h00, 1'b1, 1'b1};
    tbl[2]  = '{3'd0, 2'd1, 2'd1, 2'd0, 1'b1, 8'h01,
      1'b0, 2'd0, 8'h00, 1'b0, 2'd0, 8'h00, 1'b0, 2'd0, 8'h00,
      8'h00, 8'h01, 8'h01, 1'b0, 1'b0};
    tbl[3]  = '{3'd1, 2'd3, 2'd3, 2'd0, 1'b1, 8'h10,
      1'b1, 2'd3, 8'h10, 1'b0, 2'd0, 8'h00, 1'b0, 2'd0, 8'h00,
      8'h10, 8'h10, 8'h00, 1'b1, 1'b0};
    tbl[4]  = '{3'd5, 2'd2, 2'd0, 2'd2, 1'b0, 8'h00,
      1'b0, 2'd0, 8'h00, 1'b0, 2'd0, 8'h00, 1'b0, 2'd0, 8'h00,
      8'h08, 8'h03, 8'h0B, 1'b0, 1'b0};
    tbl[5]  = '{3'd2, 2'd3, 2'd2, 2'd0, 1'b1, 8'h00,
      1'b0, 2'd0, 8'h00, 1'b0, 2'd0, 8'h00, 1'b0, 2'd0, 8'h00,
      8'h0B, 8'h00, 8'hF4, 1'b0, 1'b0};
    tbl[6]  = '{3'd3, 2'd0, 2'd3, 2'd2, 1'b0, 8'h00,
      1'b0, 2'd0, 8'h00, 1'b0, 2'd0, 8'h00, 1'b0, 2'd0, 8'h00,
      8'hF4, 8'h0B, 8'h00, 1'b1, 1'b0};
    tbl[7]  = '{3'd4, 2'd0, 2'd2, 2'd0, 1'b1, 8'h81,
      1'b0, 2'd0, 8'h00, 1'b0, 2'd0, 8'h00, 1'b0, 2'd0, 8'h00,
      8'h0B, 8'h81, 8'h8B, 1'b0, 1'b0};
    tbl[8]  = '{3'd7, 2'd2, 2'd0, 2'd0, 1'b1, 8'h00,
      1'b0, 2'd0, 8'h00, 1'b0, 2'd0, 8'h00, 1'b0, 2'd0, 8'h00,
      8'h8B, 8'h00, 8'h8A, 1'b0, 1'b0};
    tbl[9]  = '{3'd1, 2'd1, 2'd1, 2'd2, 1'b0, 8'h00,
      1'b0, 2'd0, 8'h00, 1'b0, 2'd0, 8'h00, 1'b0, 2'd0, 8'h00,
      8'h01, 8'h8A, 8'h77, 1'b0, 1'b1};
    tbl[10] = '{3'd0, 2'd0, 2'd1, 2'd0, 1'b1, 8'h02,
      1'b0, 2'd0, 8'h00, 1'b0, 2'd0, 8'h00, 1'b1, 2'd0, 8'hAA,
      8'h77, 8'h02, 8'h79, 1'b0, 1'b0};
    tbl[11] = '{3'd0, 2'd0, 2'd0, 2'd0, 1'b1, 8'h00,
      1'b0, 2'd0, 8'h00, 1'b0, 2'd0, 8'h00, 1'b1, 2'd2, 8'h5C,
      8'h79, 8'h00, 8'h79, 1'b0, 1'b0};
    tbl[12] = '{3'd5, 2'd3, 2'd1, 2'd0, 1'b1, 8'hFF,
      1'b0, 2'd0, 8'h00, 1'b1, 2'd1, 8'hC3, 1'b0, 2'd0, 8'h00,
      8'h77, 8'hFF, 8'h88, 1'b0, 1'b0};

    // reset state
    tick(); tick();
    rst = 1'b0;
    chk("rst_ready", 32'(cmd_ready), 32'd1);
    chk("rst_alu_en", 32'(alu_en), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_ops", {alu_op, alu_a, alu_b}, 32'd0);
    chk("rst_flags", {flag_z, flag_c}, 32'd0);
    for (int i = 0; i < 4; i++) begin
      rd_addr = 2'(i); #1;
      chk($sformatf("rst_r%0d", i), 32'(rd_data), 32'd0);
    end

    do_ld(2'd2, 8'h03);
    for (int k = 0; k < 13; k++) run_vec(tbl[k], k);

    // reset during ISSUE aborts the ADD
    cmd_valid = 1'b1; cmd_op = 3'd0; cmd_rd = 2'd0;
    cmd_rs = 2'd1; cmd_rt = 2'd2; cmd_imm_en = 1'b0;
    tick();
    cmd_valid = 1'b0;
    chk("abort_issue_en", 32'(alu_en), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("abort_issue_rdy", 32'(cmd_ready), 32'd1);
    chk("abort_issue_flags", {flag_z, flag_c}, 32'd0);
    dsum = 0;
    for (int i = 0; i < 4; i++) begin
      dsum += int'(done);
      tick();
    end
    chk("abort_issue_nodone", 32'(dsum), 32'd0);
    rd_addr = 2'd0; #1;
    chk("abort_issue_r0", 32'(rd_data), 32'd0);

    // reset during WB: no writeback of INC (0x00+1)
    cmd_valid = 1'b1; cmd_op = 3'd6; cmd_rd = 2'd3;
    cmd_rs = 2'd3;
    tick();
    cmd_valid = 1'b0;
    tick();
    chk("abort_wb_done", 32'(done), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("abort_wb_nodone", 32'(done), 32'd0);
    chk("abort_wb_rdy", 32'(cmd_ready), 32'd1);
    rd_addr = 2'd3; #1;
    chk("abort_wb_r3", 32'(rd_data), 32'd0);
    chk("abort_wb_flags", {flag_z, flag_c}, 32'd0);

    // random run with the transaction model
    for (int i = 0; i < 4; i++) mregs[i] = 8'h00;
    mz = 1'b0; mc = 1'b0; phase = 0; dut_acc = 0;
    pop = '0; prd = '0; pa = '0; pb = '0; pr = '0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      if (!cmd_valid &&
          (cyc < 30 || $urandom_range(0, 3) != 0)) begin
        cmd_valid  = 1'b1;
        cmd_op     = 3'($urandom_range(0, 7));
        cmd_rd     = 2'($urandom_range(0, 3));
        cmd_rs     = 2'($urandom_range(0, 3));
        cmd_rt     = 2'($urandom_range(0, 3));
        cmd_imm_en = 1'($urandom_range(0, 1));
        cmd_imm    = 8'($urandom_range(0, 255));
      end
      ld_en   = 1'($urandom_range(0, 1));
      ld_rd   = 2'($urandom_range(0, 3));
      ld_data = 8'($urandom_range(0, 255));
      rd_addr = 2'($urandom_range(0, 3));
      #1;
      chk("rnd_rd_data", 32'(rd_data), 32'(mregs[rd_addr]));
      chk("rnd_ready", 32'(cmd_ready), 32'(phase == 0));
      chk("rnd_alu_en", 32'(alu_en), 32'(phase == 1));
      chk("rnd_done", 32'(done), 32'(phase == 2));
      chk("rnd_flags", {flag_z, flag_c}, {mz, mc});
      if (phase == 1)
        chk("rnd_operands", {alu_op, alu_a, alu_b},
            {pop, pa, pb});
      if (cyc < 30 && cmd_valid && cmd_ready) dut_acc++;
      acc = cmd_valid && (phase == 0);
      na  = mregs[cmd_rs];
      nb  = cmd_imm_en ? cmd_imm : mregs[cmd_rt];
      if (ld_en && !(phase == 2 && ld_rd == prd))
        mregs[ld_rd] = ld_data;
      if (phase == 2) begin
        mregs[prd] = pr[7:0];
        mz = (pr[7:0] == 8'h00);
        mc = pr[8];
      end
      if (acc) begin
        pop = cmd_op; prd = cmd_rd; pa = na; pb = nb;
        pr  = alu_ref(pop, pa, pb);
        phase = 1;
      end else if (phase != 0) begin
        phase = (phase + 1) % 3;
      end
      tick();
      if (acc) cmd_valid = 1'b0;
    end
    chk("rnd_b2b_accepts", 32'(dut_acc), 32'd10);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
